// File: rtl/e203_exu_flush_arb_pkg.sv
// Shared types and source indices for the EXU flush arbiter.
package e203_flush_pkg;

  typedef enum logic {
    FL_IDLE = 1'b0,
    FL_LOCK = 1'b1
  } flush_state_e;

  localparam int FLUSH_SRC_EXCP = 0;
  localparam int FLUSH_SRC_DBG  = 1;
  localparam int FLUSH_SRC_BRCH = 2;

endpackage

// File: rtl/e203_exu_flush_arb_if.sv
// Flush-source, IFU-flush and commit-lane bundle for e203_exu_flush_arb.
// pipe_flush_pc exists only when E203_FLUSH_PC_EN is defined.
interface e203_exu_flush_arb_if #(
  parameter int NUM_SRC   = 3,
  parameter int PC_SIZE   = 32,
  parameter int CMT_WIDTH = 2,
  parameter int CNT_W     = 16
);
  localparam int INSTRET_W = $clog2(CMT_WIDTH + 1);

  logic [NUM_SRC-1:0]         src_flush_req;
  logic [NUM_SRC*PC_SIZE-1:0] src_flush_op1;
  logic [NUM_SRC*PC_SIZE-1:0] src_flush_op2;
  logic [NUM_SRC-1:0]         src_flush_ack;
  logic                       pipe_flush_req;
  logic                       pipe_flush_ack;
  logic [PC_SIZE-1:0]         pipe_flush_add_op1;
  logic [PC_SIZE-1:0]         pipe_flush_add_op2;
`ifdef E203_FLUSH_PC_EN
  logic [PC_SIZE-1:0]         pipe_flush_pc;
`endif
  logic                       flush_pulse;
  logic [NUM_SRC-1:0]         flush_grant;
  logic [CMT_WIDTH-1:0]       cmt_valid;
  logic [CMT_WIDTH-1:0]       cmt_ready;
  logic [INSTRET_W-1:0]       cmt_instret_cnt;
  logic                       nonflush_cmt_ena;
  logic [CNT_W-1:0]           flush_cnt;

  modport master (
    input  src_flush_req, src_flush_op1, src_flush_op2, pipe_flush_ack, cmt_valid,
    output src_flush_ack, pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
`ifdef E203_FLUSH_PC_EN
    output pipe_flush_pc,
`endif
    output flush_pulse, flush_grant, cmt_ready, cmt_instret_cnt, nonflush_cmt_ena, flush_cnt
  );

  modport slave (
    output src_flush_req, src_flush_op1, src_flush_op2, pipe_flush_ack, cmt_valid,
    input  src_flush_ack, pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
`ifdef E203_FLUSH_PC_EN
    input  pipe_flush_pc,
`endif
    input  flush_pulse, flush_grant, cmt_ready, cmt_instret_cnt, nonflush_cmt_ena, flush_cnt
  );

endinterface

// File: rtl/e203_exu_flush_arb_prio_arb.sv
// Lowest-index-first one-hot picker with an any-request flag.
module e203_prio_arb #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         any
);

  // Isolate the lowest set bit.
  assign grant = req & (~req + N'(1));
  assign any   = |req;

endmodule

// File: rtl/e203_exu_flush_arb.sv
// Fixed-priority flush arbiter with a held LOCK state, plus in-order commit gating.
// Optional E203_FLUSH_PC_EN adds the precomputed, latched pipe_flush_pc output.
module e203_exu_flush_arb
  import e203_flush_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int PC_SIZE   = 32,
  parameter int CMT_WIDTH = 2,
  parameter int CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  e203_exu_flush_arb_if.master bus
);

  localparam int INSTRET_W = $clog2(CMT_WIDTH + 1);

  flush_state_e       state;
  logic [NUM_SRC-1:0] lock_grant;
  logic [PC_SIZE-1:0] lock_op1;
  logic [PC_SIZE-1:0] lock_op2;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_SRC-1:0] idle_grant;
  logic               idle_any;
  logic [NUM_SRC-1:0] pre_mask;
  logic [NUM_SRC-1:0] pre_grant;
  logic               pre_any_raw;
  logic               pre_any;
  logic               in_lock;
  logic               hold_lock;
  logic [NUM_SRC-1:0] cur_grant;
  logic [PC_SIZE-1:0] sel_op1;
  logic [PC_SIZE-1:0] sel_op2;
  logic               req_raw;
  logic               flush_req;
  logic               pulse;

  logic [CMT_WIDTH-1:0] cmt_rdy;
  logic [CMT_WIDTH-1:0] cmt_fire;
  logic [INSTRET_W-1:0] instret;

  assign in_lock = (state == FL_LOCK);

  e203_prio_arb #(.N(NUM_SRC)) u_idle_arb (
    .req   (bus.src_flush_req),
    .grant (idle_grant),
    .any   (idle_any)
  );

  // Only sources strictly below the latched one may pre-empt it.
  assign pre_mask = lock_grant - NUM_SRC'(1);

  e203_prio_arb #(.N(NUM_SRC)) u_pre_arb (
    .req   (bus.src_flush_req & pre_mask),
    .grant (pre_grant),
    .any   (pre_any_raw)
  );

  assign pre_any   = in_lock & pre_any_raw;
  assign hold_lock = in_lock & ~pre_any;
  assign cur_grant = in_lock ? (pre_any ? pre_grant : lock_grant) : idle_grant;

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_grant[i]) begin
        sel_op1 = sel_op1 | bus.src_flush_op1[i*PC_SIZE +: PC_SIZE];
        sel_op2 = sel_op2 | bus.src_flush_op2[i*PC_SIZE +: PC_SIZE];
      end
    end
  end

  assign req_raw   = in_lock | idle_any;
  assign flush_req = rst_n & req_raw;
  assign pulse     = flush_req & bus.pipe_flush_ack;

  assign bus.pipe_flush_req     = flush_req;
  assign bus.flush_pulse        = pulse;
  assign bus.src_flush_ack      = {NUM_SRC{pulse}} & cur_grant;
  assign bus.flush_grant        = {NUM_SRC{rst_n}} & cur_grant;
  assign bus.pipe_flush_add_op1 = {PC_SIZE{rst_n}} & (hold_lock ? lock_op1 : sel_op1);
  assign bus.pipe_flush_add_op2 = {PC_SIZE{rst_n}} & (hold_lock ? lock_op2 : sel_op2);
  assign bus.flush_cnt          = {CNT_W{rst_n}} & cnt_q;

`ifdef E203_FLUSH_PC_EN
  logic [PC_SIZE-1:0] lock_pc;
  logic [PC_SIZE-1:0] sum_pc;

  assign sum_pc            = sel_op1 + sel_op2;
  assign bus.pipe_flush_pc = {PC_SIZE{rst_n}} & (hold_lock ? lock_pc : sum_pc);
`endif

  // Ready ripples through valid lanes so retirement never skips a lane.
  always_comb begin
    cmt_rdy    = '0;
    cmt_rdy[0] = rst_n & ~req_raw;
    for (int i = 1; i < CMT_WIDTH; i++) begin
      cmt_rdy[i] = cmt_rdy[i-1] & bus.cmt_valid[i-1];
    end
  end

  assign cmt_fire = bus.cmt_valid & cmt_rdy;

  always_comb begin
    instret = '0;
    for (int i = 0; i < CMT_WIDTH; i++) begin
      instret = instret + INSTRET_W'(cmt_fire[i]);
    end
  end

  assign bus.cmt_ready        = cmt_rdy;
  assign bus.cmt_instret_cnt  = instret;
  assign bus.nonflush_cmt_ena = |cmt_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FL_IDLE;
      lock_grant <= '0;
      lock_op1   <= '0;
      lock_op2   <= '0;
      cnt_q      <= '0;
`ifdef E203_FLUSH_PC_EN
      lock_pc    <= '0;
`endif
    end else begin
      if (pulse && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state)
        FL_IDLE: begin
          if (idle_any && !bus.pipe_flush_ack) begin
            state      <= FL_LOCK;
            lock_grant <= idle_grant;
            lock_op1   <= sel_op1;
            lock_op2   <= sel_op2;
`ifdef E203_FLUSH_PC_EN
            lock_pc    <= sum_pc;
`endif
          end
        end
        FL_LOCK: begin
          if (bus.pipe_flush_ack) begin
            state      <= FL_IDLE;
            lock_grant <= '0;
          end else if (pre_any) begin
            lock_grant <= pre_grant;
            lock_op1   <= sel_op1;
            lock_op2   <= sel_op2;
`ifdef E203_FLUSH_PC_EN
            lock_pc    <= sum_pc;
`endif
          end
        end
        default: state <= FL_IDLE;
      endcase
    end
  end

endmodule
